// File: rtl/cache_set_ways_if.sv
// Lookup/write/invalidate bundle for one cache's tag and data ways.
// The master drives lk_*, w* and inv_all. The slave returns the lookup results.
interface cache_set_ways_if #(
  parameter int TARRAY_DATA_WIDTH = 24,
  parameter int DARRAY_DATA_WIDTH = 256,
  parameter int ADDR_WIDTH        = 3,
  parameter int WAY_NUM           = 4
);
  localparam int WW = $clog2(WAY_NUM);

  logic                         lk_req;
  logic [ADDR_WIDTH-1:0]        lk_addr;
  logic [TARRAY_DATA_WIDTH-1:0] lk_tag;
  logic                         wen;
  logic [ADDR_WIDTH-1:0]        waddr;
  logic [WW-1:0]                wway;
  logic                         wvalid;
  logic                         wdirty;
  logic [TARRAY_DATA_WIDTH-1:0] wtag;
  logic [DARRAY_DATA_WIDTH-1:0] wdata;
  logic                         inv_all;

  logic                         lk_done;
  logic                         hit;
  logic                         hit_dirty;
  logic [WW-1:0]                hit_way;
  logic [DARRAY_DATA_WIDTH-1:0] hit_data;
  logic [WW-1:0]                vic_way;
  logic                         vic_valid;
  logic                         vic_dirty;
  logic [TARRAY_DATA_WIDTH-1:0] vic_tag;
  logic [DARRAY_DATA_WIDTH-1:0] vic_data;

  modport master (
    output lk_req, lk_addr, lk_tag, wen, waddr, wway, wvalid, wdirty, wtag, wdata, inv_all,
    input  lk_done, hit, hit_dirty, hit_way, hit_data,
           vic_way, vic_valid, vic_dirty, vic_tag, vic_data
  );

  modport slave (
    input  lk_req, lk_addr, lk_tag, wen, waddr, wway, wvalid, wdirty, wtag, wdata, inv_all,
    output lk_done, hit, hit_dirty, hit_way, hit_data,
           vic_way, vic_valid, vic_dirty, vic_tag, vic_data
  );
endinterface

// File: rtl/cache_set_ways.sv
// Set-associative tag/data ways with tree pseudo-LRU replacement and a 1-cycle lookup.
// Handshake: lk_req is a single-cycle pulse with no backpressure. lk_done pulses exactly one cycle later. Results then hold until the next lk_done.
module cache_set_ways #(
  parameter int TARRAY_DATA_WIDTH = 24,
  parameter int DARRAY_DATA_WIDTH = 256,
  parameter int ADDR_WIDTH        = 3,
  parameter int WAY_NUM           = 4
) (
  input logic             clk,
  input logic             rst,
  cache_set_ways_if.slave bus
);
  localparam int WW   = $clog2(WAY_NUM);
  localparam int SETS = 1 << ADDR_WIDTH;
  localparam int TW   = TARRAY_DATA_WIDTH;
  localparam int DW   = DARRAY_DATA_WIDTH;

  logic [WAY_NUM-1:0] valid_q [SETS];
  logic [WAY_NUM-1:0] dirty_q [SETS];
  logic [WAY_NUM-2:0] plru_q  [SETS];
  logic [TW-1:0]      tag_q   [SETS][WAY_NUM];
  logic [DW-1:0]      data_q  [SETS][WAY_NUM];

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right). A set bit points right.
  function automatic logic [WAY_NUM-2:0] plru_touch(input logic [WAY_NUM-2:0] bits,
                                                    input logic [WW-1:0] way);
    logic [WAY_NUM-2:0] r;
    int node;
    r    = bits;
    node = 0;
    for (int l = 0; l < WW; l++) begin
      r[node] = ~way[WW-1-l];
      node    = 2 * node + 1 + int'(way[WW-1-l]);
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] plru_victim(input logic [WAY_NUM-2:0] bits);
    logic [WW-1:0] v;
    int node;
    v    = '0;
    node = 0;
    for (int l = 0; l < WW; l++) begin
      v[WW-1-l] = bits[node];
      node      = 2 * node + 1 + int'(bits[node]);
    end
    return v;
  endfunction

  logic [WAY_NUM-1:0] lk_valid;
  logic [WAY_NUM-1:0] lk_dirty;
  logic               hit_c;
  logic [WW-1:0]      hit_way_c;
  logic               inv_found;
  logic [WW-1:0]      inv_way;
  logic [WW-1:0]      vic_way_c;

  assign lk_valid = valid_q[bus.lk_addr];
  assign lk_dirty = dirty_q[bus.lk_addr];

  // Descending scans, so the lowest matching or invalid way is the one kept.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (lk_valid[w] && tag_q[bus.lk_addr][w] == bus.lk_tag) begin
        hit_c     = 1'b1;
        hit_way_c = w[WW-1:0];
      end
      if (!lk_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = w[WW-1:0];
      end
    end
    vic_way_c = inv_found ? inv_way : plru_victim(plru_q[bus.lk_addr]);
  end

  logic          lk_done_q;
  logic          hit_q;
  logic          hit_dirty_q;
  logic [WW-1:0] hit_way_q;
  logic [DW-1:0] hit_data_q;
  logic [WW-1:0] vic_way_q;
  logic          vic_valid_q;
  logic          vic_dirty_q;
  logic [TW-1:0] vic_tag_q;
  logic [DW-1:0] vic_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_done_q   <= 1'b0;
      hit_q       <= 1'b0;
      hit_dirty_q <= 1'b0;
      hit_way_q   <= '0;
      hit_data_q  <= '0;
      vic_way_q   <= '0;
      vic_valid_q <= 1'b0;
      vic_dirty_q <= 1'b0;
      vic_tag_q   <= '0;
      vic_data_q  <= '0;
    end else begin
      lk_done_q <= bus.lk_req;
      if (bus.lk_req) begin
        hit_q       <= hit_c;
        hit_way_q   <= hit_way_c;
        hit_dirty_q <= hit_c & lk_dirty[hit_way_c];
        hit_data_q  <= hit_c ? data_q[bus.lk_addr][hit_way_c] : '0;
        vic_way_q   <= vic_way_c;
        vic_valid_q <= lk_valid[vic_way_c];
        vic_dirty_q <= lk_dirty[vic_way_c];
        vic_tag_q   <= tag_q[bus.lk_addr][vic_way_c];
        vic_data_q  <= data_q[bus.lk_addr][vic_way_c];
      end
    end
  end

  // A write touch and a hit touch on the same set collide. The write touch is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (bus.inv_all) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < SETS; s++) begin
        if (bus.wen && bus.waddr == ADDR_WIDTH'(s))
          plru_q[s] <= plru_touch(plru_q[s], bus.wway);
        else if (bus.lk_req && hit_c && bus.lk_addr == ADDR_WIDTH'(s))
          plru_q[s] <= plru_touch(plru_q[s], hit_way_c);
      end
      if (bus.wen) begin
        valid_q[bus.waddr][bus.wway] <= bus.wvalid;
        dirty_q[bus.waddr][bus.wway] <= bus.wdirty;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (bus.wen && !bus.inv_all && !rst) begin
      tag_q[bus.waddr][bus.wway]  <= bus.wtag;
      data_q[bus.waddr][bus.wway] <= bus.wdata;
    end
  end

  assign bus.lk_done   = lk_done_q;
  assign bus.hit       = hit_q;
  assign bus.hit_dirty = hit_dirty_q;
  assign bus.hit_way   = hit_way_q;
  assign bus.hit_data  = hit_data_q;
  assign bus.vic_way   = vic_way_q;
  assign bus.vic_valid = vic_valid_q;
  assign bus.vic_dirty = vic_dirty_q;
  assign bus.vic_tag   = vic_tag_q;
  assign bus.vic_data  = vic_data_q;
endmodule

// File: tb/tb_cache_set_ways.sv
// Bench for cache_set_ways. A reference model uses per-way last-touch times for replacement.
// Expected lookup results are queued at issue and compared by an independent monitor.
module tb_cache_set_ways;
  localparam int TW   = 24;
  localparam int DW   = 256;
  localparam int AW   = 3;
  localparam int WAYS = 4;
  localparam int WW   = 2;
  localparam int SETS = 8;
  localparam int EW   = 2 * DW + TW + 2 * WW + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_set_ways_if #(.TARRAY_DATA_WIDTH(TW), .DARRAY_DATA_WIDTH(DW),
                      .ADDR_WIDTH(AW), .WAY_NUM(WAYS)) bus ();

  cache_set_ways #(.TARRAY_DATA_WIDTH(TW), .DARRAY_DATA_WIDTH(DW),
                   .ADDR_WIDTH(AW), .WAY_NUM(WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model state.
  bit            m_valid [SETS][WAYS];
  bit            m_dirty [SETS][WAYS];
  logic [TW-1:0] m_tag   [SETS][WAYS];
  logic [DW-1:0] m_data  [SETS][WAYS];
  int unsigned   m_ts    [SETS][WAYS];
  int unsigned   now_t = 0;

  function automatic logic [EW-1:0] pack_res(
      input logic h, input logic [WW-1:0] hw, input logic hd, input logic [DW-1:0] hdat,
      input logic [WW-1:0] vw, input logic vv, input logic vd,
      input logic [TW-1:0] vt, input logic [DW-1:0] vdat);
    return {h, hw, hd, hdat, vw, vv, vd, vt, vdat};
  endfunction

  // Each tree node points away from the half that holds the most recent touch. With no touches it points left.
  function automatic int model_plru_victim(input int s);
    int lo, size, half;
    int unsigned ml, mr;
    lo = 0;
    size = WAYS;
    while (size > 1) begin
      half = size / 2;
      ml = 0;
      mr = 0;
      for (int w = 0; w < half; w++) if (m_ts[s][lo + w] > ml) ml = m_ts[s][lo + w];
      for (int w = half; w < size; w++) if (m_ts[s][lo + w] > mr) mr = m_ts[s][lo + w];
      if (ml > mr) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_ts[s][w]    = 0;
      end
  endfunction

  task automatic expect_eq(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge. It drives one cycle of stimulus and updates the model.
  task automatic step(input bit lk, input int la, input logic [TW-1:0] lt,
                      input bit we, input int wa, input int ww, input bit wv, input bit wd,
                      input logic [TW-1:0] wt, input logic [DW-1:0] wdat, input bit inv);
    int  hw, vw;
    bit  h;
    bus.lk_req  = lk;
    bus.lk_addr = AW'(la);
    bus.lk_tag  = lt;
    bus.wen     = we;
    bus.waddr   = AW'(wa);
    bus.wway    = WW'(ww);
    bus.wvalid  = wv;
    bus.wdirty  = wd;
    bus.wtag    = wt;
    bus.wdata   = wdat;
    bus.inv_all = inv;
    h  = 1'b0;
    hw = 0;
    if (lk) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (m_valid[la][w] && m_tag[la][w] == lt) begin
          h  = 1'b1;
          hw = w;
        end
      vw = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[la][w]) vw = w;
      if (vw < 0) vw = model_plru_victim(la);
      exp_q.push_back(pack_res(h, WW'(hw), h & m_dirty[la][hw], h ? m_data[la][hw] : '0,
                               WW'(vw), m_valid[la][vw], m_dirty[la][vw],
                               m_tag[la][vw], m_data[la][vw]));
    end
    now_t++;
    if (inv) begin
      model_clear();
    end else begin
      if (we) begin
        m_valid[wa][ww] = wv;
        m_dirty[wa][ww] = wd;
        m_tag[wa][ww]   = wt;
        m_data[wa][ww]  = wdat;
        m_ts[wa][ww]    = now_t;
      end
      if (lk && h && !(we && wa == la)) m_ts[la][hw] = now_t;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic lookup(input int a, input logic [TW-1:0] t);
    step(1, a, t, 0, 0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic write(input int a, input int w, input bit v, input bit d,
                       input logic [TW-1:0] t, input logic [DW-1:0] dat);
    step(0, 0, '0, 1, a, w, v, d, t, dat, 0);
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Monitor: every lk_done must match the oldest outstanding expected result.
  always @(negedge clk) begin
    logic [EW-1:0] got, exp;
    if (!rst && bus.lk_done) begin
      got = pack_res(bus.hit, bus.hit_way, bus.hit_dirty, bus.hit_data, bus.vic_way,
                     bus.vic_valid, bus.vic_dirty, bus.vic_tag, bus.vic_data);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL lk_done_unexpected: got lk_done=1 required none outstanding");
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL lookup_result: got %0h required %0h", got, exp);
        end
      end
    end
  end

  logic [DW-1:0] ab_line;

  initial begin
    bus.lk_req = 0; bus.lk_addr = '0; bus.lk_tag = '0; bus.wen = 0; bus.waddr = '0;
    bus.wway = '0; bus.wvalid = 0; bus.wdirty = 0; bus.wtag = '0; bus.wdata = '0;
    bus.inv_all = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst_lk_done", DW'(bus.lk_done), '0);
    expect_eq("rst_hit", DW'(bus.hit), '0);
    expect_eq("rst_vic_valid", DW'(bus.vic_valid), '0);
    expect_eq("rst_hit_data", bus.hit_data, '0);
    rst = 0;
    @(posedge clk);
    #1;

    // Fresh lookup after reset: a miss whose victim is way 0 and is not valid.
    lookup(2, 24'h123);
    idle();
    expect_eq("r044_hit", DW'(bus.hit), '0);
    expect_eq("r044_vic_way", DW'(bus.vic_way), '0);
    expect_eq("r044_vic_valid", DW'(bus.vic_valid), '0);

    // Give every way a known tag and line, then invalidate everything.
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) write(s, w, 0, 0, TW'($urandom()), rand_line());
    step(0, 0, '0, 0, 0, 0, 0, 0, '0, '0, 1);

    ab_line = {32{8'hAB}};
    write(2, 1, 1, 1, 24'h123, ab_line);
    lookup(2, 24'h123);
    idle();
    expect_eq("r045_hit", DW'(bus.hit), 1);
    expect_eq("r045_hit_way", DW'(bus.hit_way), 1);
    expect_eq("r045_hit_dirty", DW'(bus.hit_dirty), 1);
    expect_eq("r045_hit_data", bus.hit_data, ab_line);

    for (int w = 0; w < WAYS; w++) write(0, w, 1, 0, TW'(24'h10 + w), rand_line());
    lookup(0, 24'h10);
    lookup(0, 24'h999);
    idle();
    expect_eq("r046_hit", DW'(bus.hit), '0);
    expect_eq("r046_vic_way", DW'(bus.vic_way), 2);
    expect_eq("r046_vic_valid", DW'(bus.vic_valid), 1);
    expect_eq("r046_vic_tag", DW'(bus.vic_tag), DW'(24'h12));

    // Same-cycle write and lookup: the lookup sees the old contents.
    step(1, 5, 24'h555, 1, 5, 3, 1, 0, 24'h555, rand_line(), 0);
    lookup(5, 24'h555);
    idle();
    expect_eq("r047_hit", DW'(bus.hit), 1);
    expect_eq("r047_hit_way", DW'(bus.hit_way), 3);

    for (int w = 0; w < WAYS; w++) write(6, w, 1, 1, TW'(24'h60 + w), rand_line());
    step(0, 0, '0, 1, 6, 0, 1, 1, 24'h777, rand_line(), 1);
    lookup(6, 24'h777);
    idle();
    expect_eq("r048_hit", DW'(bus.hit), '0);
    expect_eq("r048_vic_way", DW'(bus.vic_way), '0);
    expect_eq("r048_vic_valid", DW'(bus.vic_valid), '0);

    // Random traffic. A small tag pool produces frequent hits and same-set collisions.
    for (int i = 0; i < 600; i++) begin
      int la, wa;
      la = $urandom_range(0, SETS - 1);
      wa = ($urandom_range(0, 3) == 0) ? la : $urandom_range(0, SETS - 1);
      step($urandom_range(0, 9) < 7, la, TW'($urandom_range(0, 5)),
           $urandom_range(0, 9) < 4, wa, $urandom_range(0, WAYS - 1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           TW'($urandom_range(0, 5)), rand_line(), $urandom_range(0, 59) == 0);
    end

    // Reset arrives while a lookup is being requested. Outputs must drop before any edge.
    write(1, 0, 1, 1, 24'h42, rand_line());
    lookup(1, 24'h42);
    idle();
    expect_eq("pre_rst_hit", DW'(bus.hit), 1);
    bus.lk_req  = 1;
    bus.lk_addr = AW'(1);
    bus.lk_tag  = 24'h42;
    #1 rst = 1;
    #1;
    expect_eq("r049_lk_done", DW'(bus.lk_done), '0);
    expect_eq("r049_hit", DW'(bus.hit), '0);
    expect_eq("r049_hit_way", DW'(bus.hit_way), '0);
    expect_eq("r049_hit_dirty", DW'(bus.hit_dirty), '0);
    expect_eq("r049_hit_data", bus.hit_data, '0);
    expect_eq("r049_vic_way", DW'(bus.vic_way), '0);
    expect_eq("r049_vic_valid", DW'(bus.vic_valid), '0);
    expect_eq("r049_vic_dirty", DW'(bus.vic_dirty), '0);
    expect_eq("r049_vic_tag", DW'(bus.vic_tag), '0);
    expect_eq("r049_vic_data", bus.vic_data, '0);
    bus.lk_req = 0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    idle();
    expect_eq("post_rst_lk_done", DW'(bus.lk_done), '0);
    lookup(1, 24'h42);
    idle();
    expect_eq("post_rst_hit", DW'(bus.hit), '0);
    expect_eq("post_rst_vic_valid", DW'(bus.vic_valid), '0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding lookups required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_set_ways.md
CACHE_SET_WAYS -- requirements
Module: cache_set_ways

Interface
REQ-001 TARRAY_DATA_WIDTH, 24, tag width in bits.
REQ-002 DARRAY_DATA_WIDTH, 256, cache line width in bits.
REQ-003 ADDR_WIDTH, 3, set-index width; number of sets is 2^ADDR_WIDTH.
REQ-004 WAY_NUM, 4, associativity; power of two, 2..8; WW = log2(WAY_NUM).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 lk_req  in  1  lookup request, one per cycle.
REQ-008 lk_addr  in  ADDR_WIDTH  lookup set index.
REQ-009 lk_tag  in  TARRAY_DATA_WIDTH  lookup tag.
REQ-010 wen  in  1  way write enable.
REQ-011 waddr  in  ADDR_WIDTH  write set index.
REQ-012 wway  in  WW  write way index.
REQ-013 wvalid, wdirty  in  1 each  valid and dirty bits to store.
REQ-014 wtag  in  TARRAY_DATA_WIDTH  tag to store.
REQ-015 wdata  in  DARRAY_DATA_WIDTH  line to store.
REQ-016 inv_all  in  1  invalidate all sets.
REQ-017 lk_done  out  1  lookup results valid this cycle.
REQ-018 hit, hit_dirty  out  1 each  hit flag; dirty bit of hit way.
REQ-019 hit_way  out  WW  index of hit way.
REQ-020 hit_data  out  DARRAY_DATA_WIDTH  line of hit way.
REQ-021 vic_way  out  WW  replacement candidate for the looked-up set.
REQ-022 vic_valid, vic_dirty  out  1 each  victim's valid and dirty bits.
REQ-023 vic_tag  out  TARRAY_DATA_WIDTH  victim tag, for write-back address.
REQ-024 vic_data  out  DARRAY_DATA_WIDTH  victim line, for write-back.

Function
REQ-025 Storage: per set and way, valid, dirty, tag and data; per set, WAY_NUM-1 tree pseudo-LRU (PLRU) bits.
REQ-026 Lookup latency: exactly 1 cycle; lk_req in cycle N gives lk_done=1 and all result outputs registered in cycle N+1; lk_done=0 otherwise.
REQ-027 Result outputs hold their last values while lk_done=0.
REQ-028 Hit: valid way whose tag equals lk_tag; multiple matches, lowest index wins.
REQ-029 On miss: hit=0, hit_way=0, hit_dirty=0, hit_data=0.
REQ-030 Victim selection: lowest-index invalid way if any exists (vic_valid=0); otherwise the way the PLRU tree points to (vic_valid=1).
REQ-031 Lookup reads pre-edge state; a same-cycle write to the same set is not visible until the next lookup.
REQ-032 Write: wen stores wvalid, wdirty, wtag and wdata into (waddr, wway) at the edge.
REQ-033 PLRU touch: a lookup hit touches hit_way of lk_addr at the edge producing lk_done; a write touches wway of waddr.
REQ-034 Simultaneous touches on different sets: both applied.
REQ-035 Simultaneous touches on the same set: write touch wins.
REQ-036 Touch sets each tree node on the path to point away from the touched way.
REQ-037 Misses do not change PLRU state.
REQ-038 inv_all: clears all valid, dirty and PLRU bits in one cycle; overrides wen and touches that cycle.
REQ-039 lk_req concurrent with inv_all still completes next cycle against pre-edge state.

Reset
REQ-040 rst asserted: valid, dirty and PLRU bits clear immediately, without waiting for a clock edge.
REQ-041 rst asserted: lk_done, hit, hit_way, hit_dirty, hit_data and all vic_* outputs go to 0 immediately.
REQ-042 Tag and data storage are not reset.
REQ-043 A lookup in flight when rst asserts is dropped; no lk_done follows reset.

Verification
REQ-044 After reset, lookup set 2 tag 0x123 -> next cycle lk_done=1, hit=0, vic_way=0, vic_valid=0.
REQ-045 Write set 2 way 1 (valid=1, dirty=1, tag=0x123, data=0xAB..), then lookup set 2 tag 0x123 -> hit=1, hit_way=1, hit_dirty=1, hit_data=0xAB..
REQ-046 WAY_NUM=4: fill set 0 ways 0..3 in order, then hit way 0 -> next miss in set 0 gives vic_way=2, vic_valid=1, with the tag and data of way 2.
REQ-047 Same cycle: write set 5 way 3 and lookup set 5 with way 3's new tag -> miss; repeat lookup -> hit on way 3.
REQ-048 Fill a set, pulse inv_all with wen -> write dropped; lookup returns hit=0, vic_way=0, vic_valid=0.
REQ-049 Assert rst mid-lookup -> outputs 0 before the next edge; no lk_done follows.
